// File: rtl/core_pkg.sv
// Shared constants and helpers for the RV32 pipeline core.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ZERO     = 0;

    // Ceiling log2, minimum 1 so a 2-entry file still gets a 1-bit address.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp: address check, bypass compare, busy masking.
module regfile_rdport
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = clog2(NREG)
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] regs [NREG],
    input  logic [NREG-1:0] busy,
    input  logic            wr_ok,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic addr_ok;
    logic hit;

    always_comb begin
        addr_ok = (32'(addr) < NREG) && !((ZERO_REG != 0) && (addr == AW'(REG_ZERO)));
        // wr_ok already excludes dropped writes, so a hit implies a real write.
        hit     = (BYPASS != 0) && wr_ok && (wr_addr == addr);
        rd_data = '0;
        rd_busy = 1'b0;
        if (addr_ok) begin
            rd_data = hit ? wr_data : regs[addr];
            rd_busy = busy[addr] && !hit;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with async reset, write bypass and busy scoreboard.
module regfile_mp
    import core_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_ok;
    logic            iss_ok;

    always_comb begin
        wr_ok  = wr_en && (32'(wr_addr) < NREG)
                 && !((ZERO_REG != 0) && (wr_addr == AW'(REG_ZERO)));
        iss_ok = iss_en && (32'(iss_addr) < NREG)
                 && !((ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO)));
    end

    // Issue beats writeback on the same register: the newer producer is still pending.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < int'(NREG); r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_ok && (iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_ok && (wr_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rdport
        regfile_rdport #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .addr    (rd_addr[k*AW +: AW]),
            .regs    (regs_q),
            .busy    (busy_q),
            .wr_ok   (wr_ok),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[k*XLEN +: XLEN]),
            .rd_busy (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a 64-bit, 20-entry, 3-port, no-x0, no-bypass build.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [14:0]  a_rd_addr;
    logic [191:0] a_rd_data;
    logic [2:0]   a_rd_busy;
    logic         a_wr_en;
    logic [4:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic         a_iss_en;
    logic [4:0]   a_iss_addr;
    logic         a_flush;

    int nvec;
    int nerr;

    regfile_mp u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    regfile_mp #(
        .XLEN     (64),
        .NREG     (20),
        .NRD      (3),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) u_alt (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .iss_en   (a_iss_en),
        .iss_addr (a_iss_addr),
        .flush    (a_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
        a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_addr = '0; a_flush = 1'b0;

        #12 rst_n = 1'b1;
        rd_addr = {5'd2, 5'd1};
        #1;
        check_eq("rst_data0", rd_data[31:0], 64'h0);
        check_eq("rst_busy", {62'd0, rd_busy}, 64'h0);

        // Async reset between edges
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd6;
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        rd_addr = {5'd6, 5'd5};
        #1;
        check_eq("pre_rst_x5", rd_data[31:0], 64'hDEADBEEF);
        check_eq("pre_rst_busy6", {63'd0, rd_busy[1]}, 64'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_x5", rd_data[31:0], 64'h0);
        check_eq("async_rst_busy", {62'd0, rd_busy}, 64'h0);
        rst_n = 1'b1;
        #1;

        // Write/read and x0
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        step();
        wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr = {5'd0, 5'd7};
        #1;
        check_eq("x0_no_bypass", rd_data[63:32], 64'h0);
        check_eq("x7_stored", rd_data[31:0], 64'h12345678);
        step();
        wr_en = 1'b0;
        #1;
        check_eq("x7_read", rd_data[31:0], 64'h12345678);
        check_eq("x0_read", rd_data[63:32], 64'h0);

        // Same-cycle bypass on both ports
        rd_addr = {5'd3, 5'd3};
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        #1;
        check_eq("bypass_p0", rd_data[31:0], 64'hA5A5A5A5);
        check_eq("bypass_p1", rd_data[63:32], 64'hA5A5A5A5);
        step();
        wr_en = 1'b0;
        #1;
        check_eq("x3_stored", rd_data[31:0], 64'hA5A5A5A5);

        // Scoreboard issue / writeback
        iss_en = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd9, 5'd9};
        #1;
        check_eq("iss_same_cycle", {63'd0, rd_busy[0]}, 64'h0);
        step();
        iss_en = 1'b0;
        #1;
        check_eq("x9_busy", {63'd0, rd_busy[0]}, 64'h1);
        check_eq("x9_old", rd_data[31:0], 64'h0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        #1;
        check_eq("x9_wb_mask", {63'd0, rd_busy[0]}, 64'h0);
        check_eq("x9_wb_data", rd_data[31:0], 64'h55);
        step();
        wr_en = 1'b0;
        #1;
        check_eq("x9_cleared", {63'd0, rd_busy[1]}, 64'h0);
        check_eq("x9_data", rd_data[63:32], 64'h55);

        // Simultaneous issue and writeback, repeated issue, flush
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        step();
        wr_en = 1'b0; iss_addr = 5'd8;
        rd_addr = {5'd8, 5'd4};
        #1;
        check_eq("iss_wins_busy4", {63'd0, rd_busy[0]}, 64'h1);
        check_eq("iss_wins_data4", rd_data[31:0], 64'h44);
        step();
        #1;
        check_eq("x8_busy", {63'd0, rd_busy[1]}, 64'h1);
        step();
        flush = 1'b1; iss_addr = 5'd6;
        #1;
        check_eq("x8_reissue", {63'd0, rd_busy[1]}, 64'h1);
        step();
        flush = 1'b0; iss_en = 1'b0;
        rd_addr = {5'd8, 5'd6};
        #1;
        check_eq("flush_iss6", {63'd0, rd_busy[0]}, 64'h0);
        check_eq("flush_x8", {63'd0, rd_busy[1]}, 64'h0);
        rd_addr = {5'd0, 5'd4};
        #1;
        check_eq("flush_x4", {63'd0, rd_busy[0]}, 64'h0);

        // x0 never becomes busy
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        iss_en = 1'b0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check_eq("x0_never_busy", {63'd0, rd_busy[0]}, 64'h0);

        // Alternate build: ZERO_REG=0, BYPASS=0, NREG=20, NRD=3, XLEN=64
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 64'h0000_0000_FFFF_FFFF;
        a_rd_addr = {5'd0, 5'd0, 5'd0};
        #1;
        check_eq("alt_x0_nobyp", a_rd_data[63:0], 64'h0);
        step();
        a_wr_en = 1'b0;
        #1;
        check_eq("alt_x0_written", a_rd_data[63:0], 64'h0000_0000_FFFF_FFFF);

        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 64'hA5A5_A5A5_A5A5_A5A5;
        a_rd_addr = {5'd3, 5'd3, 5'd3};
        #1;
        check_eq("alt_nobyp_p2", a_rd_data[191:128], 64'h0);
        step();
        a_wr_en = 1'b0;
        #1;
        check_eq("alt_x3_p2", a_rd_data[191:128], 64'hA5A5_A5A5_A5A5_A5A5);
        check_eq("alt_x3_p1", a_rd_data[127:64], 64'hA5A5_A5A5_A5A5_A5A5);

        a_wr_en = 1'b1; a_wr_addr = 5'd25; a_wr_data = 64'h1234;
        a_iss_en = 1'b1; a_iss_addr = 5'd25;
        step();
        a_wr_en = 1'b0; a_iss_en = 1'b0;
        a_rd_addr = {5'd19, 5'd5, 5'd25};
        #1;
        check_eq("alt_oor_data", a_rd_data[63:0], 64'h0);
        check_eq("alt_oor_busy", {63'd0, a_rd_busy[0]}, 64'h0);
        check_eq("alt_no_alias5", a_rd_data[127:64], 64'h0);

        a_iss_en = 1'b1; a_iss_addr = 5'd19;
        step();
        a_iss_en = 1'b0;
        #1;
        check_eq("alt_x19_busy", {63'd0, a_rd_busy[2]}, 64'h1);
        a_wr_en = 1'b1; a_wr_addr = 5'd19; a_wr_data = 64'h1919;
        #1;
        check_eq("alt_nomask_busy", {63'd0, a_rd_busy[2]}, 64'h1);
        check_eq("alt_nomask_data", a_rd_data[191:128], 64'h0);
        step();
        a_wr_en = 1'b0;
        #1;
        check_eq("alt_x19_clear", {63'd0, a_rd_busy[2]}, 64'h0);
        check_eq("alt_x19_data", a_rd_data[191:128], 64'h1919);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RV32 pipeline core; next generation of the single-write, two-read core register file.
- Adds asynchronous active-low reset of all entries.
- Adds a write-to-read bypass for same-cycle writeback.
- Adds a per-register pending-write scoreboard (busy bits), which decode uses for RAW hazard stalls.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; legal range 2..64.
- NRD, 2, number of independent read ports; legal range 1..4.
- ZERO_REG, 1, 1 = register 0 hardwired to zero (RISC-V x0); 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only.
- AW (localparam), clog2(NREG), address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]; combinational.
- rd_busy  out  NRD  port k's addressed register has a pending write; combinational.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  instruction issued that will write iss_addr; marks it busy.
- iss_addr  in  AW  destination register of the issued instruction.
- flush  in  1  pipeline flush; clears every busy bit.

Behaviour:
- Reset: rst_n low asynchronously clears all NREG entries to 0 and all busy bits to 0. Outputs then follow from the cleared state: rd_data = 0 and rd_busy = 0 for all ports, unless bypass is active. Reset asserted mid-operation discards any in-flight write on that edge.
- Write: on posedge clk, if wr_en=1 then entry[wr_addr] <= wr_data. This is one-cycle latency; the rising edge replaces the old negedge-write scheme.
  - Dropped if wr_addr==0 with ZERO_REG=1.
  - Dropped if wr_addr >= NREG.
- Read, port k (pure combinational, no latency), in priority order:
  - addr==0 with ZERO_REG=1 -> 0.
  - addr >= NREG -> 0.
  - BYPASS=1, wr_en=1, wr_addr==addr, write not dropped -> wr_data.
  - otherwise -> entry[addr].
  - All NRD ports are independent; identical addresses on several ports are legal.
- Busy scoreboard, per register r, evaluated at posedge:
  - flush=1 -> busy[r] <= 0 for all r; iss_en ignored that cycle.
  - else iss_en=1 and iss_addr==r -> busy[r] <= 1. Issue wins over a simultaneous writeback to the same r, because a newer producer is pending.
  - else wr_en=1 and wr_addr==r -> busy[r] <= 0.
  - else hold.
  - Dropped addresses (0 with ZERO_REG=1, >= NREG) never become busy.
- rd_busy[k]:
  - = busy[addr_k], masked to 0 when BYPASS=1 and a non-dropped write to addr_k is present this cycle.
  - Forced 0 for dropped addresses.
  - iss_en in the same cycle does not affect rd_busy until the next cycle.
- Repeated iss_en to an already-busy register keeps it busy: no counting, single bit.
- Writeback to a non-busy register is legal; data is written and busy stays 0.
- No X propagation: unused upper-address entries (NREG not a power of two) are never referenced.

Decomposition:
- Shared package core_pkg holds:
  - XLEN default and REG_ZERO address constant.
  - clog2 function used for AW.
- One natural sub-module: regfile_rdport. It implements the per-port read mux, bypass compare and busy masking, and is instantiated NRD times in a generate loop.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset: write x5=0xDEADBEEF; pulse rst_n low between edges -> rd_data for addr 5 is 0 immediately, with no clock edge; all rd_busy = 0.
- Write/read and x0: wr x7=0x12345678, then wr x0=0xFFFFFFFF -> next cycle port0 addr7 = 0x12345678 and port1 addr0 = 0. With ZERO_REG=0, addr0 reads 0xFFFFFFFF.
- Bypass: same cycle wr_en, wr_addr=3, wr_data=0xA5A5A5A5, all NRD ports addr=3 -> every port shows 0xA5A5A5A5 combinationally. With BYPASS=0, ports show the old value until the next cycle.
- Scoreboard: iss x9 -> next cycle rd_busy=1 on port reading 9. Writeback x9=0x55 -> busy masked that cycle, with data 0x55, and cleared the cycle after.
- Simultaneous events, three checks:
  - iss x4 and wr x4 same edge -> x4 stays busy.
  - flush with iss x6 same edge -> x6 not busy.
  - flush -> all previously busy registers read rd_busy=0.
- Parameter sweep: NREG=16, NRD=3, XLEN=64 -> rd_addr 16..(2^AW-1) not applicable (AW=4); NREG=20 with addr 25 reads 0, write to 25 dropped, never busy.
